// File: rtl/wb_arbiter_pkg.sv
// Shared constants and the load-return record used by the writeback arbiter and its FIFO.
package wb_arbiter_pkg;

    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO   = 4'd0;
    localparam logic [REG_ADDR_W-1:0] REG_KERNEL = 4'd15;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } ld_entry_t;

    // Registers 0 and 15 are never written through this port.
    function automatic logic rd_writable(input logic [REG_ADDR_W-1:0] r);
        return (r != REG_ZERO) && (r != REG_KERNEL);
    endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Circular buffer for load-return entries; full/empty derive from the registered occupancy.
module wb_load_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  ld_entry_t push_entry,
    input  logic      pop,
    output ld_entry_t head,
    output logic      full,
    output logic      empty,
    output logic [AW:0] count
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    ld_entry_t       mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic [AW:0]     count_d;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_entry;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results take priority, load returns are buffered and drained in idle
// slots, and a pending-load scoreboard drives the decode stall.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic                  ld_valid,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0]     ld_data,
    output logic                  ld_ready,
    input  logic                  ld_issue,
    input  logic [REG_ADDR_W-1:0] ld_issue_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  hazard,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [DATA_W-1:0]     write_data,
    output logic                  reg_write,
    output logic [15:0]           busy_mask,
    output logic                  overflow
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic                  alu_accept;
    logic                  ld_push;
    logic                  ld_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    ld_entry_t             push_entry;
    ld_entry_t             fifo_head;

    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  we_q, we_d;
    logic [15:0]           busy_q, busy_d;
    logic                  ovf_q, ovf_d;

    assign alu_accept      = alu_valid & rd_writable(alu_rd);
    assign ld_ready        = ~fifo_full;
    assign ld_push         = ld_valid & ld_ready & rd_writable(ld_rd);
    assign ld_pop          = ~alu_accept & ~fifo_empty;
    assign push_entry.rd   = ld_rd;
    assign push_entry.data = ld_data;

    wb_load_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (ld_push),
        .push_entry (push_entry),
        .pop        (ld_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    always_comb begin
        we_d   = 1'b0;
        rd_d   = rd_q;
        data_d = data_q;
        busy_d = busy_q;
        ovf_d  = ovf_q | (ld_valid & ~ld_ready & rd_writable(ld_rd));

        if (alu_accept) begin
            we_d   = 1'b1;
            rd_d   = alu_rd;
            data_d = alu_data;
        end else if (ld_pop) begin
            we_d          = 1'b1;
            rd_d          = fifo_head.rd;
            data_d        = fifo_head.data;
            busy_d[fifo_head.rd] = 1'b0;
        end

        // Applied after the clear so a coincident set wins.
        if (ld_issue && rd_writable(ld_issue_rd)) begin
            busy_d[ld_issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q   <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
            busy_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            we_q   <= we_d;
            rd_q   <= rd_d;
            data_q <= data_d;
            busy_q <= busy_d;
            ovf_q  <= ovf_d;
        end
    end

    assign hazard     = busy_q[rs1] | busy_q[rs2] | (alu_valid & busy_q[alu_rd]);
    assign rd         = rd_q;
    assign write_data = data_q;
    assign reg_write  = we_q;
    assign busy_mask  = busy_q;
    assign overflow   = ovf_q;

    // A WAW-flagged ALU write is still taken; upstream is expected to have stalled on hazard.
    waw_accept_a: assert property (@(posedge clk) disable iff (rst)
        (alu_accept && busy_q[alu_rd]) |=> (reg_write && rd == $past(alu_rd)));

    fifo_count_a: assert property (@(posedge clk) disable iff (rst)
        fifo_count <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: vector table plus hand-written reset and hazard sequences.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [3:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic [3:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        ld_issue;
    logic [3:0]  ld_issue_rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic        hazard;
    logic [3:0]  rd;
    logic [31:0] write_data;
    logic        reg_write;
    logic [15:0] busy_mask;
    logic        overflow;

    always #5 clk = ~clk;

    wb_arbiter #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_valid    (ld_valid),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .ld_issue    (ld_issue),
        .ld_issue_rd (ld_issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .hazard      (hazard),
        .rd          (rd),
        .write_data  (write_data),
        .reg_write   (reg_write),
        .busy_mask   (busy_mask),
        .overflow    (overflow)
    );

    typedef struct {
        logic        av;
        logic [3:0]  ar;
        logic [31:0] ad;
        logic        lv;
        logic [3:0]  lr;
        logic [31:0] ld;
        logic        li;
        logic [3:0]  lir;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic        x_haz;
        logic        x_rdy;
        logic        x_we;
        logic [3:0]  x_rd;
        logic [31:0] x_data;
        logic [15:0] x_busy;
        logic        x_ovf;
    } vec_t;

    typedef struct {
        string       tag;
        logic        we;
        logic [3:0]  rd;
        logic [31:0] data;
        logic [15:0] busy;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic av, input logic [3:0] ar, input logic [31:0] ad,
        input logic lv, input logic [3:0] lr, input logic [31:0] ld,
        input logic li, input logic [3:0] lir,
        input logic [3:0] s1, input logic [3:0] s2,
        input logic x_haz, input logic x_rdy,
        input logic x_we, input logic [3:0] x_rd, input logic [31:0] x_data,
        input logic [15:0] x_busy, input logic x_ovf);
        vec_t v;
        v.av = av; v.ar = ar; v.ad = ad;
        v.lv = lv; v.lr = lr; v.ld = ld;
        v.li = li; v.lir = lir; v.s1 = s1; v.s2 = s2;
        v.x_haz = x_haz; v.x_rdy = x_rdy;
        v.x_we = x_we; v.x_rd = x_rd; v.x_data = x_data;
        v.x_busy = x_busy; v.x_ovf = x_ovf;
        return v;
    endfunction

    task automatic drive_idle();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
        ld_issue = 1'b0; ld_issue_rd = '0; rs1 = '0; rs2 = '0;
    endtask

    // One cycle: drive at negedge, check combinational outputs, queue the expected write,
    // then compare registered outputs just after the rising edge.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        alu_valid = v.av; alu_rd = v.ar; alu_data = v.ad;
        ld_valid = v.lv; ld_rd = v.lr; ld_data = v.ld;
        ld_issue = v.li; ld_issue_rd = v.lir; rs1 = v.s1; rs2 = v.s2;
        #1;
        check({tag, " hazard"}, 32'(hazard), 32'(v.x_haz));
        check({tag, " ld_ready"}, 32'(ld_ready), 32'(v.x_rdy));
        e.tag = tag; e.we = v.x_we; e.rd = v.x_rd; e.data = v.x_data;
        e.busy = v.x_busy; e.ovf = v.x_ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, " reg_write"}, 32'(reg_write), 32'(e.we));
        if (e.we) begin
            check({e.tag, " rd"}, 32'(rd), 32'(e.rd));
            check({e.tag, " write_data"}, write_data, e.data);
        end
        check({e.tag, " busy_mask"}, 32'(busy_mask), 32'(e.busy));
        check({e.tag, " overflow"}, 32'(overflow), 32'(e.ovf));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " reg_write"}, 32'(reg_write), 32'd0);
        check({tag, " rd"}, 32'(rd), 32'd0);
        check({tag, " write_data"}, write_data, 32'd0);
        check({tag, " busy_mask"}, 32'(busy_mask), 32'd0);
        check({tag, " overflow"}, 32'(overflow), 32'd0);
        check({tag, " ld_ready"}, 32'(ld_ready), 32'd1);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        #1;
        check_reset_state(tag);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive_idle();
        do_reset("por");

        // Single ALU write appears for one cycle.
        tbl.push_back(mk(1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // Load issue / return / writeback clears busy and hazard together.
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 5, 5, 0, 0, 1, 0, 0, 0, 16'h0020, 0));
        tbl.push_back(mk(0, 0, 0, 1, 5, 32'h11, 0, 0, 0, 5, 1, 1, 0, 0, 0, 16'h0020, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 1, 1, 1, 5, 32'h11, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0, 0));
        // Load waits behind three ALU writes.
        tbl.push_back(mk(1, 1, 32'hA1, 1, 7, 32'h77, 0, 0, 0, 0, 0, 1, 1, 1, 32'hA1, 0, 0));
        tbl.push_back(mk(1, 2, 32'hA2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 32'hA2, 0, 0));
        tbl.push_back(mk(1, 3, 32'hA3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 32'hA3, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 32'h77, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // Five pushes under continuous ALU traffic: fifth dropped, overflow sticky.
        for (int i = 0; i < 5; i++) begin
            tbl.push_back(mk(1, 4, 32'h100 + 32'(i), 1, 4'(8 + i), 32'h800 + 32'(i), 0, 0, 0, 0,
                             0, (i < 4), 1, 4, 32'h100 + 32'(i), 0, (i == 4)));
        end
        // Drain in FIFO order; ready stays low in the cycle the full FIFO pops.
        for (int i = 0; i < 4; i++) begin
            tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, (i != 0), 1, 4'(8 + i),
                             32'h800 + 32'(i), 0, 1));
        end
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        do_reset("rst2");

        // Writes to registers 0 and 15 are discarded everywhere.
        apply(mk(1, 0, 32'hBAD0, 1, 15, 32'hBAD1, 1, 15, 0, 0, 0, 1, 0, 0, 0, 0, 0), "rsv0");
        apply(mk(0, 0, 0, 1, 0, 32'hBAD2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), "rsv1");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), "rsv2");

        // Build three buffered loads with busy 0x00A0, including a WAW ALU write.
        apply(mk(1, 2, 32'hC1, 1, 5, 32'h1, 1, 5, 0, 0, 0, 1, 1, 2, 32'hC1, 16'h0020, 0), "mid0");
        apply(mk(1, 2, 32'hC2, 1, 7, 32'h2, 1, 7, 0, 0, 0, 1, 1, 2, 32'hC2, 16'h00A0, 0), "mid1");
        apply(mk(1, 7, 32'hC3, 1, 5, 32'h3, 0, 0, 0, 0, 1, 1, 1, 7, 32'hC3, 16'h00A0, 0), "waw");
        apply(mk(1, 2, 32'hC4, 0, 0, 0, 0, 0, 5, 0, 1, 1, 1, 2, 32'hC4, 16'h00A0, 0), "mid3");

        // Asynchronous reset in the middle of a cycle clears outputs without a clock edge.
        #2;
        rst = 1'b1;
        drive_idle();
        #1;
        check_reset_state("async_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 5, 0, 1, 0, 0, 0, 0, 0), $sformatf("post%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
